pattern_ramp_gen: RTL and testbench

- Parametrised ramp generator for the pattern datapath.
- Advances an output code by a programmable step on each rising edge of an advance strobe.
- Four end-of-range behaviours: saturate, wrap, triangle and hold.
- Drives the pattern DAC word; generalises the fixed 12-bit, four-step ramp to any width, any step and a programmable top.

---
 rtl/pattern_ramp_gen.sv | 138 +++++++++++++
 tb/tb_pattern_ramp_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_ramp_gen.sv
// Programmable-step ramp generator for the pattern DAC word: saturate, wrap, triangle and hold.
// Optional macro PATTERN_RAMP_GEN_LIMIT_EN adds a limit port that sets the top code.
module pattern_ramp_gen #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ramp_enb,
  input  logic              delta,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
`ifdef PATTERN_RAMP_GEN_LIMIT_EN
  input  logic [WIDTH-1:0]  limit,
`endif
  output logic [WIDTH-1:0]  out,
  output logic              dir_down,
  output logic              wrap,
  output logic              sat
);

  typedef enum logic [1:0] {
    MODE_SAT  = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  mode_e            mode_w;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             delta_q;
  logic             adv;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] s;
  logic             over_top;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   top_ext;
  logic [WIDTH:0]   wrap_sum;

  assign mode_w   = mode_e'(mode);
  assign step_ext = WIDTH'(step);

`ifdef PATTERN_RAMP_GEN_LIMIT_EN
  assign top      = limit;
  assign s        = (step_ext > top) ? top : step_ext;
  // out can sit above top only after limit has been lowered under it.
  assign over_top = (out_q > top);
`else
  assign top      = '1;
  assign s        = step_ext;
  assign over_top = 1'b0;
`endif

  assign top_ext  = {1'b0, top};
  assign sum      = {1'b0, out_q} + {1'b0, s};
  assign wrap_sum = sum - (top_ext + {{WIDTH{1'b0}}, 1'b1});
  assign adv      = delta & ~delta_q;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (!ramp_enb) begin
      out_d = '0;
      dir_d = 1'b0;
    end else if (adv) begin
      unique case (mode_w)
        MODE_SAT: begin
          if (over_top || sum >= top_ext) out_d = top;
          else                            out_d = sum[WIDTH-1:0];
        end
        MODE_WRAP: begin
          if (over_top) begin
            out_d  = '0;
            wrap_d = 1'b1;
          end else if (sum > top_ext) begin
            out_d  = wrap_sum[WIDTH-1:0];
            wrap_d = 1'b1;
          end else begin
            out_d = sum[WIDTH-1:0];
          end
        end
        MODE_TRI: begin
          if (over_top) begin
            out_d = top;
            dir_d = 1'b1;
          end else if (!dir_q) begin
            if (sum >= top_ext) begin
              out_d  = top;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              out_d = sum[WIDTH-1:0];
            end
          end else begin
            // Descending: landing on or below zero turns the ramp back up.
            if (out_q <= s) begin
              out_d  = '0;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else begin
              out_d = out_q - s;
            end
          end
        end
        MODE_HOLD: begin
          out_d = out_q;
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      delta_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      delta_q <= delta;
    end
  end

  assign out      = out_q;
  assign dir_down = dir_q;
  assign wrap     = wrap_q;
  assign sat      = (mode_w == MODE_SAT) && (out_q == top);

endmodule

// File: tb/tb_pattern_ramp_gen.sv
// Directed bench for pattern_ramp_gen; covers reset, each mode, coincident events and, with
// PATTERN_RAMP_GEN_LIMIT_EN, the programmable top.
module tb_pattern_ramp_gen;
  localparam int W  = 12;
  localparam int SW = 11;

`ifdef PATTERN_RAMP_GEN_LIMIT_EN
  localparam int TRI_STEP = 40;
  localparam int TRI_SEQ [7] = '{40, 80, 100, 60, 20, 0, 40};
`else
  localparam int TRI_STEP = 1500;
  localparam int TRI_SEQ [7] = '{1500, 3000, 4095, 2595, 1095, 0, 1500};
`endif
  localparam int TRI_DIR  [7] = '{0, 0, 1, 1, 1, 0, 0};
  localparam int TRI_WRAP [7] = '{0, 0, 1, 0, 0, 1, 0};

  logic          clk = 1'b0;
  logic          rst;
  logic          ramp_enb;
  logic          delta;
  logic [SW-1:0] step;
  logic [1:0]    mode;
  logic [W-1:0]  limit;
  logic [W-1:0]  out;
  logic          dir_down;
  logic          wrap;
  logic          sat;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_ramp_gen #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ramp_enb (ramp_enb),
    .delta    (delta),
    .step     (step),
    .mode     (mode),
`ifdef PATTERN_RAMP_GEN_LIMIT_EN
    .limit    (limit),
`endif
    .out      (out),
    .dir_down (dir_down),
    .wrap     (wrap),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  // Raise delta at a negedge and return just after the advancing posedge.
  task automatic edge_delta();
    @(negedge clk) delta = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_delta();
    @(negedge clk) delta = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    edge_delta();
    release_delta();
  endtask

  task automatic clear_ramp();
    @(negedge clk) begin
      ramp_enb = 1'b0;
      delta    = 1'b0;
    end
    @(posedge clk);
    @(negedge clk) ramp_enb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ramp_enb = 1'b0; delta = 1'b1; step = 1; mode = 2'b00; limit = 12'd4095;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out !== 12'd0)  begin n_fail++; $display("FAIL reset_out got=%0d exp=0", out); end
    n_checks++; if (dir_down !== 1'b0) begin n_fail++; $display("FAIL reset_dir got=%b exp=0", dir_down); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    n_checks++; if (sat !== 1'b0)  begin n_fail++; $display("FAIL reset_sat got=%b exp=0", sat); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) ramp_enb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out !== 12'd0) begin n_fail++; $display("FAIL enable_held_high got=%0d exp=0", out); end
    release_delta();
    edge_delta();
    n_checks++; if (out !== 12'd1) begin n_fail++; $display("FAIL first_advance got=%0d exp=1", out); end
    release_delta();
  endtask

  task automatic test_saturate();
    int exp_seq [4] = '{1290, 2580, 3870, 4095};
    clear_ramp();
    step = 1290; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      pulse();
      n_checks++;
      if (out !== W'(exp_seq[i])) begin
        n_fail++; $display("FAIL sat_seq[%0d] got=%0d exp=%0d", i, out, exp_seq[i]);
      end
    end
    n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_level got=%b exp=1", sat); end
    edge_delta();
    n_checks++; if (out !== 12'd4095) begin n_fail++; $display("FAIL sat_hold got=%0d exp=4095", out); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sat_no_wrap got=%b exp=0", wrap); end
    release_delta();
  endtask

  task automatic test_wrap();
    clear_ramp();
    step = 16; mode = 2'b01;
    for (int i = 0; i < 255; i++) pulse();
    n_checks++; if (out !== 12'd4080) begin n_fail++; $display("FAIL wrap_preset got=%0d exp=4080", out); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL wrap_sat_low got=%b exp=0", sat); end
    edge_delta();
    n_checks++; if (out !== 12'd0) begin n_fail++; $display("FAIL wrap_roll got=%0d exp=0", out); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got=%b exp=1", wrap); end
    @(posedge clk); #1;
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_width got=%b exp=0", wrap); end
    release_delta();
    pulse();
    n_checks++; if (out !== 12'd16) begin n_fail++; $display("FAIL wrap_next got=%0d exp=16", out); end
  endtask

  task automatic test_hold_and_zero_step();
    @(negedge clk) mode = 2'b11;
    edge_delta();
    n_checks++; if (out !== 12'd16) begin n_fail++; $display("FAIL hold_out got=%0d exp=16", out); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap got=%b exp=0", wrap); end
    release_delta();
    @(negedge clk) begin mode = 2'b00; step = 0; end
    pulse();
    n_checks++; if (out !== 12'd16) begin n_fail++; $display("FAIL zero_step got=%0d exp=16", out); end
  endtask

  task automatic test_triangle();
`ifdef PATTERN_RAMP_GEN_LIMIT_EN
    limit = 12'd100;
`endif
    clear_ramp();
    step = TRI_STEP; mode = 2'b10;
    for (int i = 0; i < 7; i++) begin
      edge_delta();
      n_checks++;
      if (out !== W'(TRI_SEQ[i])) begin
        n_fail++; $display("FAIL tri_out[%0d] got=%0d exp=%0d", i, out, TRI_SEQ[i]);
      end
      n_checks++;
      if (dir_down !== 1'(TRI_DIR[i])) begin
        n_fail++; $display("FAIL tri_dir[%0d] got=%b exp=%0d", i, dir_down, TRI_DIR[i]);
      end
      n_checks++;
      if (wrap !== 1'(TRI_WRAP[i])) begin
        n_fail++; $display("FAIL tri_wrap[%0d] got=%b exp=%0d", i, wrap, TRI_WRAP[i]);
      end
      release_delta();
    end
  endtask

  task automatic test_enable_fall();
    @(negedge clk) begin
      delta    = 1'b1;
      ramp_enb = 1'b0;
    end
    @(posedge clk); #1;
    n_checks++; if (out !== 12'd0) begin n_fail++; $display("FAIL enb_fall_out got=%0d exp=0", out); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL enb_fall_wrap got=%b exp=0", wrap); end
    @(negedge clk) begin
      delta    = 1'b0;
      ramp_enb = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_triangle();
    clear_ramp();
    step = TRI_STEP; mode = 2'b10;
    for (int i = 0; i < 4; i++) pulse();
    n_checks++; if (out !== W'(TRI_SEQ[3]) || dir_down !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup got=%0d/%b exp=%0d/1", out, dir_down, TRI_SEQ[3]);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out !== 12'd0 || dir_down !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got=%0d/%b exp=0/0", out, dir_down);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef PATTERN_RAMP_GEN_LIMIT_EN
  task automatic test_limit();
    limit = 12'd100; clear_ramp();
    step = 30; mode = 2'b00;
    for (int i = 0; i < 3; i++) pulse();
    n_checks++; if (out !== 12'd90) begin n_fail++; $display("FAIL lim_preset got=%0d exp=90", out); end
    @(negedge clk) begin limit = 12'd50; mode = 2'b01; end
    edge_delta();
    n_checks++; if (out !== 12'd0 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL lim_wrap got=%0d/%b exp=0/1", out, wrap);
    end
    release_delta();
    limit = 12'd100; clear_ramp();
    mode = 2'b00;
    for (int i = 0; i < 3; i++) pulse();
    @(negedge clk) limit = 12'd50;
    pulse();
    n_checks++; if (out !== 12'd50 || sat !== 1'b1) begin
      n_fail++; $display("FAIL lim_sat got=%0d/%b exp=50/1", out, sat);
    end
    limit = 12'd0; clear_ramp();
    mode = 2'b10;
    edge_delta();
    n_checks++; if (out !== 12'd0 || dir_down !== 1'b1 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL lim0_up got=%0d/%b/%b exp=0/1/1", out, dir_down, wrap);
    end
    release_delta();
    edge_delta();
    n_checks++; if (out !== 12'd0 || dir_down !== 1'b0 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL lim0_down got=%0d/%b/%b exp=0/0/1", out, dir_down, wrap);
    end
    release_delta();
  endtask
`endif

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_hold_and_zero_step();
    test_triangle();
    test_enable_fall();
    test_rst_mid_triangle();
`ifdef PATTERN_RAMP_GEN_LIMIT_EN
    test_limit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
